// File: rtl/b_seq_pkg.sv
// Shared types and default geometry for the B-side address sequencer.
package b_seq_pkg;

    typedef enum logic [1:0] {BS_IDLE, BS_RUN, BS_DONE} bseq_state_t;

    localparam int BSEQ_AW     = 4;
    localparam int BSEQ_LAST   = 8;
    localparam int BSEQ_PASSES = 2;
    localparam int BSEQ_PIDX_W = 8;

    // pass_idx is 8 bits wide, so at most 256 passes are representable
    function automatic bit bseq_params_ok(input int aw, input int last, input int passes);
        return (last > 0) && (last < (1 << aw)) && (passes >= 1) && (passes <= (1 << BSEQ_PIDX_W));
    endfunction

endpackage

// File: rtl/b_seq_pass_ctr.sv
// Pass counter for the B-side sequencer: increment/clear with a last-pass flag.
module b_seq_pass_ctr
    import b_seq_pkg::*;
#(
    parameter int PASSES = BSEQ_PASSES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc_i,
    input  logic                   clr_i,
    output logic [BSEQ_PIDX_W-1:0] cnt_o,
    output logic                   last_o
);

    localparam logic [BSEQ_PIDX_W-1:0] LAST_IDX = BSEQ_PIDX_W'(PASSES - 1);

    logic [BSEQ_PIDX_W-1:0] cnt_q;
    logic [BSEQ_PIDX_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + BSEQ_PIDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/b_address_sequencer.sv
// B-side address sequencer: sweeps 0..LAST for PASSES passes per start, then pulses done.
// Optional hold input (freezes the sweep in RUN) is compiled in with BSEQ_HOLD_EN.
module b_address_sequencer
    import b_seq_pkg::*;
#(
    parameter int AW     = BSEQ_AW,
    parameter int LAST   = BSEQ_LAST,
    parameter int PASSES = BSEQ_PASSES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
`ifdef BSEQ_HOLD_EN
    input  logic                   hold,
`endif
    output logic [AW-1:0]          addressBcounter,
    output logic                   busy,
    output logic                   done,
    output logic [BSEQ_PIDX_W-1:0] pass_idx
);

    if (!bseq_params_ok(AW, LAST, PASSES)) begin : g_bad_params
        $error("b_address_sequencer: illegal AW/LAST/PASSES combination");
    end

    localparam logic [AW-1:0] LAST_A = AW'(LAST);

    bseq_state_t   state_q;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          done_q;

    logic hold_w;
    logic in_run;
    logic step;
    logic at_last;
    logic pc_inc;
    logic pc_clr;
    logic pc_last;

`ifdef BSEQ_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign in_run  = (state_q == BS_RUN);
    assign step    = in_run && !abort && !hold_w;
    assign at_last = (addr_q == LAST_A);
    // The counter is cleared on the wrap of the final pass so DONE already shows pass_idx=0
    assign pc_inc  = step && at_last && !pc_last;
    assign pc_clr  = (in_run && abort) || (step && at_last && pc_last);

    b_seq_pass_ctr #(
        .PASSES (PASSES)
    ) u_pass_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (pc_inc),
        .clr_i  (pc_clr),
        .cnt_o  (pass_idx),
        .last_o (pc_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BS_IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                BS_IDLE: begin
                    addr_q <= '0;
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q <= BS_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                BS_RUN: begin
                    if (abort) begin
                        state_q <= BS_IDLE;
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                    end else if (!hold_w) begin
                        if (at_last) begin
                            addr_q <= '0;
                            if (pc_last) begin
                                state_q <= BS_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                BS_DONE: begin
                    state_q <= BS_IDLE;
                    addr_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= BS_IDLE;
                    addr_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign addressBcounter = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_b_address_sequencer.sv
// Self-checking bench for b_address_sequencer: vector table, directed corner sequences,
// and a randomized run against a run-position reference model.
module tb_b_address_sequencer;
    import b_seq_pkg::*;

    localparam int L       = BSEQ_LAST;
    localparam int P       = BSEQ_PASSES;
    localparam int RUN_LEN = P * (L + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, abort = 1'b0, hold = 1'b0;
    logic [3:0] addr;
    logic       busy, done;
    logic [7:0] pidx;

    logic       start2 = 1'b0, abort2 = 1'b0, hold2 = 1'b0;
    logic [3:0] addr2;
    logic       busy2, done2;
    logic [7:0] pidx2;

    int  n_pass = 0;
    int  n_total = 0;
    bit  clk_run = 1'b1;

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    b_address_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
`ifdef BSEQ_HOLD_EN
        .hold            (hold),
`endif
        .addressBcounter (addr),
        .busy            (busy),
        .done            (done),
        .pass_idx        (pidx)
    );

    b_address_sequencer #(.AW(4), .LAST(15), .PASSES(1)) dut15 (
        .clk             (clk),
        .reset           (reset),
        .start           (start2),
        .abort           (abort2),
`ifdef BSEQ_HOLD_EN
        .hold            (hold2),
`endif
        .addressBcounter (addr2),
        .busy            (busy2),
        .done            (done2),
        .pass_idx        (pidx2)
    );

    function automatic int pk(input int a, input int b, input int d, input int p);
        return (a << 10) | (b << 9) | (d << 8) | p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_main(input string name, input int a, input int b, input int d, input int p);
        chk(name, pk(int'(addr), int'(busy), int'(done), int'(pidx)), pk(a, b, d, p));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit s;
        bit a;
        int ea;
        int eb;
        int ed;
        int ep;
    } vec_t;

    // Drives one run from IDLE; optionally re-pulses start at position restart_k and
    // holds for hold_n cycles at position hold_k. Expectations come from the run position.
    task automatic run_full(input int restart_k, input int hold_k, input int hold_n, input string tag);
        int k = 0;
        int h = 0;
        int busy_cnt = 0;
        int guard = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (k < RUN_LEN && guard < 200) begin
            expect_main(tag, k % (L + 1), 1, 0, k / (L + 1));
            if (busy) busy_cnt++;
            start = (k == restart_k && h == 0);
            if (k == hold_k && h < hold_n) begin
                hold = 1'b1;
                h++;
            end else begin
                hold = 1'b0;
                k++;
            end
            guard++;
            tick();
        end
        start = 1'b0;
        hold  = 1'b0;
        expect_main({tag, "_done"}, 0, 0, 1, 0);
        tick();
        expect_main({tag, "_idle"}, 0, 0, 0, 0);
        chk({tag, "_busy_len"}, busy_cnt, RUN_LEN + hold_n);
    endtask

    vec_t vt[10];

    initial begin
        int dcount;
        int mode;
        int k;
        bit hold_eff;

        // ---- reset state
        reset = 1'b1;
        tick();
        tick();
        expect_main("reset_state", 0, 0, 0, 0);
        chk("reset_state15", pk(int'(addr2), int'(busy2), int'(done2), int'(pidx2)), 0);
        reset = 1'b0;
        tick();

        // ---- vector table, applied from IDLE
        vt[0] = '{1, 1, 0, 0, 0, 0};  // start & abort together: abort wins
        vt[1] = '{0, 0, 0, 0, 0, 0};
        vt[2] = '{1, 0, 0, 1, 0, 0};
        vt[3] = '{0, 0, 1, 1, 0, 0};
        vt[4] = '{1, 0, 2, 1, 0, 0};  // start in RUN ignored
        vt[5] = '{0, 1, 0, 0, 0, 0};
        vt[6] = '{0, 1, 0, 0, 0, 0};
        vt[7] = '{1, 0, 0, 1, 0, 0};
        vt[8] = '{0, 0, 1, 1, 0, 0};
        vt[9] = '{0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            start = vt[i].s;
            abort = vt[i].a;
            tick();
            expect_main($sformatf("vec%0d", i), vt[i].ea, vt[i].eb, vt[i].ed, vt[i].ep);
        end
        start = 1'b0;
        abort = 1'b0;
        tick();

        // ---- full run, then a run with start re-pulsed at addr 3
        run_full(-1, -1, 0, "full_run");
        run_full(3, -1, 0, "restart_ignored");

        // ---- abort at addr 5 of pass 1
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < L + 1 + 5; i++) tick();
        expect_main("pre_abort", 5, 1, 0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_main("post_abort", 0, 0, 0, 0);
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        // ---- async reset with the clock stopped mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < L + 3; i++) tick();
        expect_main("pre_reset", 2, 1, 0, 1);
        @(negedge clk);
        clk_run = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        expect_main("async_reset", 0, 0, 0, 0);
        clk_run = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_main("after_reset_idle", 0, 0, 0, 0);
        end

        // ---- full-range instance: LAST=15, PASSES=1
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("sweep15", pk(int'(addr2), int'(busy2), int'(done2), int'(pidx2)), pk(i, 1, 0, 0));
            tick();
        end
        chk("sweep15_done", pk(int'(addr2), int'(busy2), int'(done2), int'(pidx2)), pk(0, 0, 1, 0));
        tick();
        chk("sweep15_idle", pk(int'(addr2), int'(busy2), int'(done2), int'(pidx2)), 0);

`ifdef BSEQ_HOLD_EN
        // ---- hold for 3 cycles at addr 2, then abort during hold
        run_full(-1, 2, 3, "hold_run");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        hold = 1'b1;
        tick();
        expect_main("held", 2, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        hold  = 1'b0;
        expect_main("abort_over_hold", 0, 0, 0, 0);
        tick();
`endif

        // ---- randomized run against a run-position model
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        mode = 0;   // 0 idle, 1 running, 2 done pulse
        k = 0;
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 15) == 0);
            hold  = ($urandom_range(0, 3) == 0);
`ifdef BSEQ_HOLD_EN
            hold_eff = hold;
`else
            hold_eff = 1'b0;
`endif
            tick();
            case (mode)
                0: if (start && !abort) begin mode = 1; k = 0; end
                1: begin
                    if (abort) mode = 0;
                    else if (!hold_eff) begin
                        k++;
                        if (k == RUN_LEN) mode = 2;
                    end
                end
                default: mode = 0;
            endcase
            if (mode == 1) expect_main("random", k % (L + 1), 1, 0, k / (L + 1));
            else expect_main("random", 0, 0, (mode == 2) ? 1 : 0, 0);
        end
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
